// File: rtl/gf_mux_n_seq.sv
// N-channel glitch-free data mux: select changes run break-before-make, and the
// registered output holds idle_val for BREAK_CYCLES+1 cycles across a switch.
module gf_mux_n_seq #(
    parameter  int N            = 4,
    parameter  int WIDTH        = 8,
    parameter  int BREAK_CYCLES = 2,
    parameter  int RESET_SEL    = 0,
    localparam int SEL_W        = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   ch_data,
    input  logic [N-1:0]         ch_en,
    input  logic [WIDTH-1:0]     idle_val,
    input  logic                 sel_valid,
    input  logic [SEL_W-1:0]     sel_req,
    output logic                 sel_ready,
    output logic [WIDTH-1:0]     mux_out,
    output logic [SEL_W-1:0]     cur_sel,
    output logic                 switching,
    output logic                 sel_done,
    output logic                 sel_err
);

    localparam int CNT_W = (BREAK_CYCLES > 1) ? $clog2(BREAK_CYCLES) : 1;

    typedef enum logic {
        ST_RUN,
        ST_BREAK
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [SEL_W-1:0]   r_cur_sel;
    logic [SEL_W-1:0]   w_cur_sel_nxt;
    logic [SEL_W-1:0]   r_target;
    logic [SEL_W-1:0]   w_target_nxt;
    logic [WIDTH-1:0]   r_mux;
    logic [WIDTH-1:0]   w_mux_nxt;
    logic [WIDTH-1:0]   w_run_val;
    logic               r_done;
    logic               w_done_nxt;
    logic               r_err;
    logic               w_err_nxt;
    logic               w_accept;
    logic               w_req_oob;

    assign sel_ready = (r_state == ST_RUN) & ~rst;
    assign w_accept  = sel_valid & sel_ready;
    assign w_req_oob = ({{(32-SEL_W){1'b0}}, sel_req} >= 32'(N));
    assign w_run_val = ch_en[r_cur_sel] ? ch_data[r_cur_sel*WIDTH +: WIDTH] : idle_val;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_cur_sel_nxt = r_cur_sel;
        w_target_nxt  = r_target;
        w_mux_nxt     = w_run_val;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_accept) begin
                    if (w_req_oob) begin
                        w_err_nxt = 1'b1;
                    end else if (sel_req == r_cur_sel) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        // Break starts on the accepting edge itself.
                        w_state_nxt  = ST_BREAK;
                        w_cnt_nxt    = CNT_W'(BREAK_CYCLES - 1);
                        w_target_nxt = sel_req;
                        w_mux_nxt    = idle_val;
                    end
                end
            end
            ST_BREAK: begin
                w_mux_nxt = idle_val;
                if (r_cnt == '0) begin
                    w_cur_sel_nxt = r_target;
                    w_state_nxt   = ST_RUN;
                    w_done_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_cnt     <= '0;
            r_cur_sel <= SEL_W'(RESET_SEL);
            r_target  <= SEL_W'(RESET_SEL);
            r_mux     <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_cur_sel <= w_cur_sel_nxt;
            r_target  <= w_target_nxt;
            r_mux     <= w_mux_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign mux_out   = r_mux;
    assign cur_sel   = r_cur_sel;
    assign switching = (r_state == ST_BREAK);
    assign sel_done  = r_done;
    assign sel_err   = r_err;

endmodule
